// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the register bank.
//   master modport : the OPB side (address, byte enables, write data, select)
//   slave modport  : the register bank (read data, acknowledge, tied-off status)
// Vectors keep the OPB big-endian numbering: bit 0 is the MSB.
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB-slave bank of C_NUM_REGS 32-bit shadow registers plus one commit register.
// Writes land in shadows; a write to the commit register copies the masked
// shadows to the fabric outputs in a single cycle and bumps a 16-bit counter.
//   OPB_Clk, OPB_Rst_n : sole clock, asynchronous active-low reset
//   opb                : OPB slave bus (see the interface file)
//   user_data_out      : register i at bits [32i+31:32i]
//   user_data_valid    : one-cycle strobe per register when it is committed
//
// state   | meaning
// ST_IDLE | waiting for a selected, in-range transfer
// ST_ACK  | acknowledge cycle; read data on Sl_DBus, no new accept
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
    parameter int          C_NUM_REGS    = 4,
    parameter logic [31:0] C_PULSE_MASK  = 32'h0000_0000,
    parameter bit          C_AUTO_COMMIT = 1'b0,
    parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [32*C_NUM_REGS-1:0]      user_data_out,
    output logic [C_NUM_REGS-1:0]         user_data_valid
);
    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    localparam logic [31:0] SPAN     = C_HIGHADDR - C_BASEADDR;
    localparam logic [29:0] K_COMMIT = 30'(C_NUM_REGS);

    state_t state, state_next;

    logic [31:0] abus, wdata, offset, rd_value, rd_q;
    logic [3:0]  be;
    logic [29:0] k;
    logic        hit, accept, wr_en, rd_en;
    logic [15:0] commit_count;
    logic [C_NUM_REGS-1:0] commit_en, valid_q;
    logic [31:0] shadow      [C_NUM_REGS];
    logic [31:0] shadow_next [C_NUM_REGS];
    logic [31:0] out_q       [C_NUM_REGS];
    logic        unused_bits;

    // Numeric (LSB = bit 0) views of the big-endian bus; be[3] is the MSB byte.
    assign abus  = opb.OPB_ABus;
    assign wdata = opb.OPB_DBus;
    assign be    = opb.OPB_BE;

    // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
    assign offset      = abus - C_BASEADDR;
    assign k           = offset[31:2];
    assign hit         = (offset <= SPAN);
    assign unused_bits = &{1'b0, opb.OPB_seqAddr, offset[1:0]};

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (opb.OPB_select && hit) begin
                    accept     = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_en = accept & ~opb.OPB_RNW;
    assign rd_en = accept &  opb.OPB_RNW;

    always_comb begin
        rd_value  = '0;
        commit_en = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            shadow_next[i] = shadow[i];
            if (k == 30'(i)) begin
                rd_value = shadow[i];
                if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) shadow_next[i][8*b +: 8] = wdata[8*b +: 8];
                    end
                    commit_en[i] = C_AUTO_COMMIT;
                end
            end
            if (wr_en && (k == K_COMMIT) && wdata[i]) commit_en[i] = 1'b1;
        end
        if (k == K_COMMIT) rd_value = {16'h0000, commit_count};
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rd_q         <= '0;
            valid_q      <= '0;
            commit_count <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow[i] <= C_RESET_VALUE;
                out_q[i]  <= C_PULSE_MASK[i] ? 32'h0 : C_RESET_VALUE;
            end
        end else begin
            // Cleared whenever no read is accepted, so Sl_DBus is zero outside read acks.
            rd_q    <= rd_en ? rd_value : 32'h0;
            valid_q <= commit_en;
            if (wr_en && (k == K_COMMIT)) commit_count <= commit_count + 16'd1;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow[i] <= shadow_next[i];
                if (commit_en[i])         out_q[i] <= shadow_next[i];
                else if (C_PULSE_MASK[i]) out_q[i] <= 32'h0;
            end
        end
    end

    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++) user_data_out[32*i +: 32] = out_q[i];
    end

    assign user_data_valid = valid_q;
    assign opb.Sl_DBus     = rd_q;
    assign opb.Sl_xferAck  = (state == ST_ACK);
    assign opb.Sl_errAck   = 1'b0;
    assign opb.Sl_retry    = 1'b0;
    assign opb.Sl_toutSup  = 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`timescale 1ns/1ps
module tb_opb_register_bank_ppc2simulink;
    localparam int          N     = 4;
    localparam logic [31:0] RSTV  = 32'hA5A5_A5A5;
    localparam logic [31:0] CADDR = 32'h0000_0010;

    typedef struct {
        logic [31:0] data;
        longint      t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [32*N-1:0] udo;
    logic [N-1:0]    udv;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_model = 0;
    exp_t exp_q[$];

    opb_register_bank_ppc2simulink_if bus();

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(32'h0), .C_HIGHADDR(32'hFF), .C_NUM_REGS(N),
        .C_PULSE_MASK(32'h4), .C_AUTO_COMMIT(1'b0), .C_RESET_VALUE(RSTV)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus),
        .user_data_out(udo), .user_data_valid(udv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] out_of(input int i);
        return udo[32*i +: 32];
    endfunction

    // Monitor: every acknowledge must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.Sl_xferAck) begin
            if (exp_q.size() == 0) begin
                check("spurious_ack", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_data", bus.Sl_DBus, e.data);
                check("ack_time", 32'($time), 32'(e.t));
            end
        end else if (bus.Sl_DBus !== 32'h0) begin
            check("idle_dbus", bus.Sl_DBus, 32'h0);
        end
    end

    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] exp_rd, input bit exp_ack);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = data;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        if (exp_ack) begin
            e.data = rnw ? exp_rd : 32'h0;
            e.t    = longint'($time) + 5;
            exp_q.push_back(e);
        end
        #1;
        bus.OPB_select = 1'b0;
        bus.OPB_DBus   = 32'h0;
    endtask

    // Commit writes with mask 0 and select held high: one accept every other edge.
    task automatic burst_commit(input int n);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        bus.OPB_ABus   = CADDR;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_BE     = 4'hF;
        bus.OPB_DBus   = 32'h0;
        bus.OPB_select = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            e.data = 32'h0;
            e.t    = longint'($time) + 5;
            exp_q.push_back(e);
            @(posedge clk);
        end
        #1;
        bus.OPB_select = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.OPB_ABus = 32'h0; bus.OPB_BE = 4'h0; bus.OPB_DBus = 32'h0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_out0", out_of(0), RSTV);
        check("rst_out1", out_of(1), RSTV);
        check("rst_out2_pulse", out_of(2), 32'h0);
        check("rst_out3", out_of(3), RSTV);
        check("rst_valid", 32'(udv), 32'h0);
        check("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
        check("rst_dbus", bus.Sl_DBus, 32'h0);
        check("rst_tied", {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
        xfer(CADDR, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);

        // Partial byte-enable write keeps the upper bytes
        xfer(32'h4, 1'b0, 4'b0011, 32'h1234_5678, 32'h0, 1'b1);
        check("be_out1_unchanged", out_of(1), RSTV);
        xfer(32'h4, 1'b1, 4'hF, 32'h0, 32'hA5A5_5678, 1'b1);

        // Shadow writes then commit mask 0x9
        for (int i = 0; i < N; i++) xfer(32'(4*i), 1'b0, 4'hF, 32'(i + 1), 32'h0, 1'b1);
        xfer(CADDR, 1'b0, 4'h0, 32'h9, 32'h0, 1'b1);
        cnt_model = (cnt_model + 1) & 16'hFFFF;
        check("c9_out0", out_of(0), 32'h1);
        check("c9_out1", out_of(1), RSTV);
        check("c9_out2", out_of(2), 32'h0);
        check("c9_out3", out_of(3), 32'h4);
        check("c9_valid", 32'(udv), 32'h9);
        @(posedge clk); #1;
        check("c9_valid_drop", 32'(udv), 32'h0);
        xfer(CADDR, 1'b1, 4'hF, 32'h0, 32'(cnt_model), 1'b1);
        xfer(32'h4, 1'b1, 4'hF, 32'h0, 32'h2, 1'b1);

        // Pulse-mode register
        xfer(32'h8, 1'b0, 4'hF, 32'h0000_DEAD, 32'h0, 1'b1);
        xfer(CADDR, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1);
        cnt_model = (cnt_model + 1) & 16'hFFFF;
        check("pulse_out2", out_of(2), 32'h0000_DEAD);
        check("pulse_valid", 32'(udv), 32'h4);
        @(posedge clk); #1;
        check("pulse_out2_drop", out_of(2), 32'h0);
        check("pulse_valid_drop", 32'(udv), 32'h0);
        xfer(CADDR, 1'b1, 4'hF, 32'h0, 32'(cnt_model), 1'b1);

        // Unused words inside the range acknowledge and read zero
        xfer(32'h14, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer(32'h14, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer(32'hFC, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        check("hole_out0", out_of(0), 32'h1);

        // Counter wrap through 0xFFFF -> 0x0000 with mask 0
        burst_commit(65536 - cnt_model);
        cnt_model = 0;
        xfer(CADDR, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        check("wrap_out0", out_of(0), 32'h1);
        check("wrap_out1", out_of(1), RSTV);
        check("wrap_out2", out_of(2), 32'h0);
        check("wrap_out3", out_of(3), 32'h4);

        // Out-of-range select is ignored
        @(negedge clk);
        bus.OPB_ABus = 32'h100; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("oor_no_ack", 32'(bus.Sl_xferAck), 32'h0);
        end
        bus.OPB_select = 1'b0;

        // Reset right after a write is accepted: no ack, shadow restored
        xfer(32'h0, 1'b0, 4'hF, 32'h0000_0055, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", 32'(bus.Sl_xferAck), 32'h0);
        check("rst_mid_dbus", bus.Sl_DBus, 32'h0);
        rst_n = 1'b1;
        check("rst_mid_out0", out_of(0), RSTV);
        xfer(32'h0, 1'b1, 4'hF, 32'h0, RSTV, 1'b1);
        xfer(CADDR, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);

        repeat (3) @(negedge clk);
        check("pending_acks", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
